gf16_inv_iter: RTL and testbench

Iterative GF(2^4) inverter stage that sits directly upstream of the combined S-box output multiplier. It produces the 4-bit inverse nibble E consumed there. It also carries the A/B nibble operands and their parity bits alongside, so that all multiplier operands arrive aligned. The inverse is computed as D^14 over three clocks of square-and-multiply, behind a single-entry valid/ready handshake.

---
 rtl/gf16_inv_iter.sv | 118 +++++++++++
 tb/tb_gf16_inv_iter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gf16_inv_iter.sv
// Iterative GF(2^4) inverter (E = D^14, modulus x^4+x+1) feeding the S-box output multiplier.
// The A/B operand nibbles and their parity bits ride alongside so every multiplier operand arrives aligned.
module gf16_inv_iter (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] D,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  input  logic       Ap_in,
  input  logic       Bp_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] E,
  output logic [3:0] A_out,
  output logic [3:0] B_out,
  output logic       Ap_out,
  output logic       Bp_out,
  output logic [1:0] dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // Input side accepts only in IDLE; output side holds E/sidebands in DONE until out_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, SQ2 = 2'd1, SQ3 = 2'd2, DONE = 2'd3} state_t;

  state_t     state_q, state_d;
  logic [3:0] t_q, t_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       ap_q, ap_d;
  logic       bp_q, bp_d;

  function automatic logic [3:0] gf_sq(input logic [3:0] d);
    gf_sq = {d[3], d[1] ^ d[3], d[2], d[0] ^ d[2]};
  endfunction

  // Carry-less product, then fold x^4..x^6 back using x^4 = x + 1.
  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) p = p ^ ({3'd0, x} << i);
    end
    gf_mul = {p[3] ^ p[6],
              p[2] ^ p[5] ^ p[6],
              p[1] ^ p[4] ^ p[5],
              p[0] ^ p[4]};
  endfunction

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    ap_d    = ap_q;
    bp_d    = bp_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          t_d     = gf_sq(D);
          acc_d   = gf_sq(D);
          a_d     = A_in;
          b_d     = B_in;
          ap_d    = Ap_in;
          bp_d    = Bp_in;
          state_d = SQ2;
        end
      end
      SQ2: begin
        t_d     = gf_sq(t_q);
        acc_d   = gf_mul(acc_q, gf_sq(t_q));
        state_d = SQ3;
      end
      SQ3: begin
        t_d     = gf_sq(t_q);
        acc_d   = gf_mul(acc_q, gf_sq(t_q));
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= 4'd0;
      acc_q   <= 4'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      ap_q    <= 1'b0;
      bp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ap_q    <= ap_d;
      bp_q    <= bp_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !reset;
  assign out_valid   = (state_q == DONE);
  assign E           = acc_q;
  assign A_out       = a_q;
  assign B_out       = b_q;
  assign Ap_out      = ap_q;
  assign Bp_out      = bp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gf16_inv_iter.sv
// Directed bench for gf16_inv_iter: inverse table sweep, sideband hold, backpressure,
// mid-flight reset and a random-ready stream checked against an expected queue.
module tb_gf16_inv_iter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] D, A_in, B_in;
  logic       Ap_in, Bp_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] E, A_out, B_out;
  logic       Ap_out, Bp_out;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  logic [3:0] inv_tbl [16] = '{4'd0, 4'd1, 4'd9, 4'd14, 4'd13, 4'd11, 4'd7, 4'd6,
                               4'd15, 4'd2, 4'd12, 4'd5, 4'd10, 4'd4, 4'd3, 4'd8};
  logic [3:0] exp_q [$];

  gf16_inv_iter dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .A_in(A_in), .B_in(B_in), .Ap_in(Ap_in), .Bp_in(Bp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .E(E), .A_out(A_out), .B_out(B_out), .Ap_out(Ap_out), .Bp_out(Bp_out),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference multiply: schoolbook with reduce-as-you-shift.
  function automatic logic [3:0] ref_mul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] r, s;
    r = 4'd0;
    s = x;
    for (int i = 0; i < 4; i++) begin
      if (y[i]) r = r ^ s;
      s = s[3] ? ({s[2:0], 1'b0} ^ 4'b0011) : {s[2:0], 1'b0};
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one input, wait (bounded) for out_valid, capture the result, then hand off.
  task automatic run(input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                     input logic ap, input logic bp,
                     output logic [3:0] e, output logic [3:0] ao, output logic [3:0] bo,
                     output logic apo, output logic bpo);
    int n;
    D = d; A_in = a; B_in = b; Ap_in = ap; Bp_in = bp;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      step();
      n++;
    end
    if (!out_valid) chk("run_timeout", {7'd0, out_valid}, 8'd1);
    e = E; ao = A_out; bo = B_out; apo = Ap_out; bpo = Bp_out;
    step();
  endtask

  initial begin
    logic [3:0] e, ao, bo;
    logic       apo, bpo;
    logic [3:0] ds [8];
    int sent, got, cyc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    D = 4'd0; A_in = 4'd0; B_in = 4'd0; Ap_in = 1'b0; Bp_in = 1'b0;
    step();
    chk("rst_in_ready_low", {7'd0, in_ready}, 8'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_E", {4'd0, E}, 8'd0);
    chk("rst_sidebands", {A_out, B_out}, 8'd0);
    chk("rst_parity", {6'd0, Ap_out, Bp_out}, 8'd0);
    chk("rst_state", {6'd0, dbg_state}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);

    // First transfer, traced edge by edge: accept, SQ2, SQ3, then DONE on the third edge.
    out_ready = 1'b1;
    D = 4'h2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_sq2_in_ready", {7'd0, in_ready}, 8'd0);
    chk("t1_sq2_out_valid", {7'd0, out_valid}, 8'd0);
    step();
    chk("t1_sq3_in_ready", {7'd0, in_ready}, 8'd0);
    chk("t1_sq3_out_valid", {7'd0, out_valid}, 8'd0);
    step();
    chk("t1_done_out_valid", {7'd0, out_valid}, 8'd1);
    chk("t1_done_in_ready", {7'd0, in_ready}, 8'd0);
    chk("t1_E", {4'd0, E}, 8'h09);
    step();
    chk("t1_idle_in_ready", {7'd0, in_ready}, 8'd1);
    chk("t1_idle_out_valid", {7'd0, out_valid}, 8'd0);

    // Full sweep against the inverse table, plus D*E == 1 for nonzero D.
    for (int d = 0; d < 16; d++) begin
      run(4'(d), 4'd0, 4'd0, 1'b0, 1'b0, e, ao, bo, apo, bpo);
      chk($sformatf("sweep_E_d%0d", d), {4'd0, e}, {4'd0, inv_tbl[d]});
      if (d != 0) chk($sformatf("sweep_prod_d%0d", d), {4'd0, ref_mul(4'(d), e)}, 8'd1);
    end

    // Sideband pass-through and hold while the pins move.
    run(4'h3, 4'hA, 4'h5, 1'b1, 1'b0, e, ao, bo, apo, bpo);
    chk("sb_E", {4'd0, e}, 8'h0E);
    chk("sb_AB", {ao, bo}, 8'hA5);
    chk("sb_parity", {6'd0, apo, bpo}, 8'b10);
    A_in = 4'h3; B_in = 4'hC; Ap_in = 1'b0; Bp_in = 1'b1;
    step();
    step();
    chk("sb_hold_AB", {A_out, B_out}, 8'hA5);
    chk("sb_hold_parity", {6'd0, Ap_out, Bp_out}, 8'b10);

    // Backpressure: result held in DONE, a second input during the stall is refused.
    out_ready = 1'b0;
    D = 4'hF; A_in = 4'h1; B_in = 4'h2; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("bp_reach_done", {7'd0, out_valid}, 8'd1);
    D = 4'h1; A_in = 4'h7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_hold_valid_%0d", i), {7'd0, out_valid}, 8'd1);
      chk($sformatf("bp_hold_E_%0d", i), {4'd0, E}, 8'h08);
      chk($sformatf("bp_hold_in_ready_%0d", i), {7'd0, in_ready}, 8'd0);
      step();
    end
    chk("bp_hold_A", {4'd0, A_out}, 8'h01);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_after_handoff_valid", {7'd0, out_valid}, 8'd0);
    chk("bp_after_handoff_in_ready", {7'd0, in_ready}, 8'd1);
    step();
    chk("bp_stall_input_dropped", {6'd0, dbg_state}, 8'd0);
    chk("bp_stall_A_unchanged", {4'd0, A_out}, 8'h01);

    // Reset while D=7 sits in SQ3.
    D = 4'h7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rs_in_sq3", {6'd0, dbg_state}, 8'd2);
    reset = 1'b1;
    #1;
    chk("rs_in_ready_forced_low", {7'd0, in_ready}, 8'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rs_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rs_E", {4'd0, E}, 8'd0);
    chk("rs_state", {6'd0, dbg_state}, 8'd0);
    step();
    step();
    chk("rs_no_late_valid", {7'd0, out_valid}, 8'd0);
    run(4'h7, 4'd0, 4'd0, 1'b0, 1'b0, e, ao, bo, apo, bpo);
    chk("rs_retry_E", {4'd0, e}, 8'h06);

    // Stream: in_valid held high, out_ready random, scoreboard keeps order.
    for (int i = 0; i < 8; i++) ds[i] = 4'($urandom_range(0, 15));
    sent = 0; got = 0; cyc = 0;
    while (got < 8 && cyc < 400) begin
      in_valid = (sent < 8);
      D = ds[sent < 8 ? sent : 7];
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_ready && out_valid) chk("st_ready_valid_excl", 8'd1, 8'd0);
      if (in_valid && in_ready) begin
        exp_q.push_back(inv_tbl[D]);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("st_unexpected_result", {4'd0, E}, 8'hFF);
        else chk($sformatf("st_E_%0d", got), {4'd0, E}, {4'd0, exp_q.pop_front()});
        got++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("st_all_results", got[7:0], 8'd8);
    chk("st_queue_empty", exp_q.size() == 0 ? 8'd1 : 8'd0, 8'd1);
    step();
    chk("st_idle_at_end", {6'd0, dbg_state}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
